scoreboard_register_file: RTL
=============================

SCOREBOARD_REGISTER_FILE -- requirements
Module: scoreboard_register_file

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, register width in bits.
REQ-002 SHALL have parameter ADDR_WIDTH, default 5, address width; depth = 2**ADDR_WIDTH.
REQ-003 SHALL have parameter ZERO_REG, default 1, when 1 register 0 reads 0 and is never written or claimed.
REQ-004 SHALL have parameter BYPASS, default 1, when 1 same-cycle write data forwards to read ports.
REQ-005 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-006 SHALL have port rst_n  input  1  reset, synchronous, active-low.
REQ-007 SHALL have ports read_sel_1, read_sel_2  input  ADDR_WIDTH  read addresses.
REQ-008 SHALL have ports read_data_1, read_data_2  output  DATA_WIDTH  combinational read data.
REQ-009 SHALL have ports read_ready_1, read_ready_2  output  1  operand valid (not pending, or forwarded).
REQ-010 SHALL have ports RegWrite  input  1, write_address  input  ADDR_WIDTH, write_data  input  DATA_WIDTH  writeback port.
REQ-011 SHALL have ports claim_en  input  1, claim_address  input  ADDR_WIDTH  mark destination pending.
REQ-012 SHALL have port claim_stall  output  1  claim refused this cycle.
REQ-013 SHALL have port flush  input  1  clear all pending bits.
REQ-014 SHALL have port pending_count  output  ADDR_WIDTH+1  number of pending registers.

Function
REQ-015 Write: RegWrite=1 at rising edge SHALL store write_data to write_address; visible next cycle (latency 1); writes to register 0 dropped when ZERO_REG=1.
REQ-016 Read: read_data_n SHALL be combinational from storage; read of register 0 returns 0 when ZERO_REG=1.
REQ-017 Bypass: when BYPASS=1, RegWrite=1, write_address==read_sel_n and write is not dropped, read_data_n SHALL equal write_data in that cycle.
REQ-018 read_ready_n SHALL be 1 when pending[read_sel_n]=0, or when BYPASS=1 and a non-dropped write to read_sel_n occurs this cycle; 0 otherwise; register 0 always ready when ZERO_REG=1.
REQ-019 Write to a pending register SHALL clear its pending bit at the edge, unless a claim to the same address is accepted in that cycle.
REQ-020 claim_stall SHALL equal claim_en & pending[claim_address] & ~(RegWrite & write_address==claim_address) & ~flush; combinational.
REQ-021 Claim accepted (claim_en & ~claim_stall, address non-zero or ZERO_REG=0) SHALL set pending[claim_address] at the edge; claim of register 0 with ZERO_REG=1 SHALL be accepted and ignored.
REQ-022 Simultaneous accepted claim and write to the same address: data written, pending bit ends 1.
REQ-023 flush=1 SHALL clear every pending bit at the edge, overriding same-cycle claims; same-cycle write still stores data.
REQ-024 pending_count SHALL be registered, equal to popcount of pending bits after each edge; max 2**ADDR_WIDTH, never wraps.
REQ-025 pending_count SHALL update incrementally (+1 accepted new claim, -1 cleared pending, net 0 when both), set to 0 on flush.

Reset
REQ-026 rst_n=0 at a rising edge SHALL clear all registers to 0, all pending bits to 0, pending_count to 0; overrides RegWrite, claim_en, flush.
REQ-027 During reset cycle claim_stall SHALL be 0 is not required; after the reset edge all read_ready_n = 1, read_data_n = 0.
REQ-028 Reset mid-operation SHALL discard all pending state; no partial write survives the reset edge.

Structure
REQ-029 Shared package SHALL hold default DATA_WIDTH/ADDR_WIDTH constants and the ZERO_REG/BYPASS defaults used by the CPU datapath.
REQ-030 One sub-module SHALL be natural: pending_scoreboard (pending bits, claim_stall, pending_count); storage and bypass in the top.
REQ-031 No initial blocks; all state defined by reset.

Verification
REQ-032 Reset then read all addresses -> read_data=0, read_ready=1, pending_count=0.
REQ-033 Write 0xDEADBEEF to r5, read_sel_1=5 same cycle -> read_data_1=0xDEADBEEF (BYPASS=1); with BYPASS=0 -> old value 0 until next cycle.
REQ-034 Claim r7, next cycle read r7 -> read_ready=0, pending_count=1; claim r7 again -> claim_stall=1; write r7=0x12 -> ready=1 forwarded, pending_count=0 next cycle.
REQ-035 Claim r3 and write r3=0x55 same cycle while r3 pending -> claim_stall=0, r3=0x55, pending stays 1, pending_count unchanged.
REQ-036 Claim r1..r4, then flush with claim r9 -> all pending 0, pending_count=0, r9 ready.
REQ-037 Write r0=0xFFFFFFFF and claim r0 (ZERO_REG=1) -> read r0=0, ready=1, pending_count=0.

Source files
------------

// File: rtl/scoreboard_register_file_pkg.sv
// rtl/scoreboard_register_file_pkg.sv - shared defaults for the scoreboarded register file
package scoreboard_register_file_pkg;

  localparam int DEFAULT_DATA_WIDTH = 32;
  localparam int DEFAULT_ADDR_WIDTH = 5;
  localparam bit DEFAULT_ZERO_REG   = 1'b1;
  localparam bit DEFAULT_BYPASS     = 1'b1;

endpackage

// File: rtl/scoreboard_register_file_pending_scoreboard.sv
// rtl/scoreboard_register_file_pending_scoreboard.sv - pending bits, claim arbitration and pending count
module pending_scoreboard
  import scoreboard_register_file_pkg::*;
#(
  parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH,
  parameter bit ZERO_REG   = DEFAULT_ZERO_REG
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        reg_write_raw,
  input  logic                        write_effective,
  input  logic [ADDR_WIDTH-1:0]       write_address,
  input  logic                        claim_en,
  input  logic [ADDR_WIDTH-1:0]       claim_address,
  input  logic                        flush,
  output logic [(1<<ADDR_WIDTH)-1:0]  pending_o,
  output logic                        claim_stall,
  output logic [ADDR_WIDTH:0]         pending_count
);

  localparam int DEPTH = 1 << ADDR_WIDTH;

  logic [DEPTH-1:0]  pending_q, pending_d;
  logic [ADDR_WIDTH:0] count_q, count_d;
  logic claim_accepted, claim_effective, same_addr, inc, dec;

  assign same_addr = (write_address == claim_address);

  // Stall uses the raw write strobe; a dropped r0 write never meets a pending r0 anyway.
  assign claim_stall = claim_en & pending_q[claim_address]
                     & ~(reg_write_raw & same_addr) & ~flush;

  assign claim_accepted  = claim_en & ~claim_stall;
  assign claim_effective = claim_accepted & ~(ZERO_REG && (claim_address == '0));

  // A claim only meets an already-pending bit when a same-address write clears it: net zero.
  assign inc = claim_effective & ~pending_q[claim_address];
  assign dec = write_effective & pending_q[write_address]
             & ~(claim_effective & same_addr);

  always_comb begin
    pending_d = pending_q;
    count_d   = count_q + {{ADDR_WIDTH{1'b0}}, inc} - {{ADDR_WIDTH{1'b0}}, dec};
    if (write_effective) pending_d[write_address] = 1'b0;
    if (claim_effective) pending_d[claim_address] = 1'b1;
    if (flush) begin
      pending_d = '0;
      count_d   = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pending_q <= '0;
      count_q   <= '0;
    end else begin
      pending_q <= pending_d;
      count_q   <= count_d;
    end
  end

  assign pending_o     = pending_q;
  assign pending_count = count_q;

endmodule

// File: rtl/scoreboard_register_file.sv
// rtl/scoreboard_register_file.sv - register file with write-back bypass and pending-operand scoreboard
module scoreboard_register_file
  import scoreboard_register_file_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH,
  parameter bit ZERO_REG   = DEFAULT_ZERO_REG,
  parameter bit BYPASS     = DEFAULT_BYPASS
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [ADDR_WIDTH-1:0] read_sel_1,
  input  logic [ADDR_WIDTH-1:0] read_sel_2,
  output logic [DATA_WIDTH-1:0] read_data_1,
  output logic [DATA_WIDTH-1:0] read_data_2,
  output logic                  read_ready_1,
  output logic                  read_ready_2,
  input  logic                  RegWrite,
  input  logic [ADDR_WIDTH-1:0] write_address,
  input  logic [DATA_WIDTH-1:0] write_data,
  input  logic                  claim_en,
  input  logic [ADDR_WIDTH-1:0] claim_address,
  output logic                  claim_stall,
  input  logic                  flush,
  output logic [ADDR_WIDTH:0]   pending_count
);

  localparam int DEPTH = 1 << ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] regs_q [DEPTH];
  logic [DEPTH-1:0]      pending;
  logic                  write_effective;

  assign write_effective = RegWrite & ~(ZERO_REG && (write_address == '0));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) regs_q[i] <= '0;
    end else if (write_effective) begin
      regs_q[write_address] <= write_data;
    end
  end

  pending_scoreboard #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .ZERO_REG   (ZERO_REG)
  ) u_pending (
    .clk             (clk),
    .rst_n           (rst_n),
    .reg_write_raw   (RegWrite),
    .write_effective (write_effective),
    .write_address   (write_address),
    .claim_en        (claim_en),
    .claim_address   (claim_address),
    .flush           (flush),
    .pending_o       (pending),
    .claim_stall     (claim_stall),
    .pending_count   (pending_count)
  );

  logic fwd_1, fwd_2, zero_1, zero_2;

  assign fwd_1  = BYPASS && write_effective && (write_address == read_sel_1);
  assign fwd_2  = BYPASS && write_effective && (write_address == read_sel_2);
  assign zero_1 = ZERO_REG && (read_sel_1 == '0);
  assign zero_2 = ZERO_REG && (read_sel_2 == '0);

  always_comb begin
    read_data_1 = regs_q[read_sel_1];
    read_data_2 = regs_q[read_sel_2];
    if (zero_1) read_data_1 = '0;
    if (zero_2) read_data_2 = '0;
    if (fwd_1)  read_data_1 = write_data;
    if (fwd_2)  read_data_2 = write_data;
  end

  assign read_ready_1 = zero_1 | ~pending[read_sel_1] | fwd_1;
  assign read_ready_2 = zero_2 | ~pending[read_sel_2] | fwd_2;

endmodule
